// File: rtl/seven_segment_pkg.sv
// Shared types and constants for the debug seven-segment scan path.
// Converter state encoding and the double-dabble nibble adjust live here.
package seven_segment_pkg;

    localparam int BCD_DIGITS_MAX = 10;
    localparam int BIN_WIDTH      = 32;
    localparam int BCD_WIDTH      = BCD_DIGITS_MAX * 4;
    localparam logic [3:0] DASH_CODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } conv_state_e;

    // Add 3 to every nibble >= 5 ahead of the next left shift.
    function automatic logic [BCD_WIDTH-1:0] dabble_adjust(
        input logic [BCD_WIDTH-1:0] bcd
    );
        logic [BCD_WIDTH-1:0] res;
        res = '0;
        for (int i = 0; i < BCD_DIGITS_MAX; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end else begin
                res[i*4 +: 4] = bcd[i*4 +: 4];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble: one shift per cycle, 32 shifts per value.
// Pulses COMMIT_STROBE for one cycle once the result in BCD is final.
module bin_to_bcd_converter
    import seven_segment_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [BIN_WIDTH-1:0] IN,
    output logic                 BUSY,
    output logic                 COMMIT_STROBE,
    output logic [BCD_WIDTH-1:0] BCD
);

    conv_state_e          state_q, state_d;
    logic [BIN_WIDTH-1:0] cap_q, cap_d;
    logic [BIN_WIDTH-1:0] shift_q, shift_d;
    logic [BCD_WIDTH-1:0] bcd_q, bcd_d;
    logic [4:0]           cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 commit_q, commit_d;
    logic [BCD_WIDTH-1:0] adj;

    // Next-state: capture on change, shift 32 times, then strobe.
    always_comb begin
        state_d  = state_q;
        cap_d    = cap_q;
        shift_d  = shift_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        commit_d = 1'b0;
        adj      = dabble_adjust(bcd_q);
        unique case (state_q)
            IDLE: begin
                if (IN != cap_q) begin
                    cap_d   = IN;
                    shift_d = IN;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, shift_d} = {adj, shift_q} << 1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                busy_d   = 1'b0;
                commit_d = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Converter state and registered handshake outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            cap_q    <= '0;
            shift_q  <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cap_q    <= cap_d;
            shift_q  <= shift_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            commit_q <= commit_d;
        end
    end

    assign BUSY          = busy_q;
    assign COMMIT_STROBE = commit_q;
    assign BCD           = bcd_q;

endmodule

// File: rtl/seven_segment_scanner.sv
// Binary-to-BCD display front end with time-multiplexed digit scan.
// Outputs decode registered state only; IN never reaches them directly.
module seven_segment_scanner
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [BIN_WIDTH-1:0]  IN,
    output logic [BIN_WIDTH-1:0]  DIGIT_CODE,
    output logic [NUM_DIGITS-1:0] DIGIT_SEL,
    output logic                  BUSY,
    output logic                  OVERFLOW
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DISP_W = NUM_DIGITS * 4;

    logic [BCD_WIDTH-1:0]  conv_bcd;
    logic                  conv_commit;
    logic [DISP_W-1:0]     display_q, display_d;
    logic [NUM_DIGITS-1:0] keep_q, keep_d;
    logic                  ovf_q, ovf_d;
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  any_hi;
    int                    msd;
    logic [NUM_DIGITS-1:0] onehot;
    logic [3:0]            nib;

    bin_to_bcd_converter u_conv (
        .CLK           (CLK),
        .RESET         (RESET),
        .IN            (IN),
        .BUSY          (BUSY),
        .COMMIT_STROBE (conv_commit),
        .BCD           (conv_bcd)
    );

    // On commit: load digits, flag overflow, rebuild leading-zero mask.
    always_comb begin
        display_d = display_q;
        keep_d    = keep_q;
        ovf_d     = ovf_q;
        any_hi    = 1'b0;
        msd       = 0;
        for (int i = 0; i < BCD_DIGITS_MAX; i++) begin
            if (i >= NUM_DIGITS && conv_bcd[i*4 +: 4] != 4'd0) begin
                any_hi = 1'b1;
            end
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (conv_bcd[i*4 +: 4] != 4'd0) begin
                msd = i;
            end
        end
        if (conv_commit) begin
            display_d = conv_bcd[DISP_W-1:0];
            ovf_d     = any_hi;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                keep_d[i] = (i <= msd);
            end
        end
    end

    // Prescaler and scan index; index steps on prescaler terminal count.
    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        idx_d = idx_q;
        if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_d = '0;
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Display, overflow, mask and scan registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            display_q <= '0;
            keep_q    <= NUM_DIGITS'(1);
            ovf_q     <= 1'b0;
            pre_q     <= '0;
            idx_q     <= '0;
        end else begin
            display_q <= display_d;
            keep_q    <= keep_d;
            ovf_q     <= ovf_d;
            pre_q     <= pre_d;
            idx_q     <= idx_d;
        end
    end

    // Slot decode: select the digit, dash on overflow, blank leading zeros.
    always_comb begin
        onehot = '0;
        nib    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                onehot[i] = 1'b1;
                nib       = display_q[i*4 +: 4];
            end
        end
        DIGIT_SEL = onehot;
        if (BLANK_LZ && !ovf_q) begin
            DIGIT_SEL = onehot & keep_q;
        end
        DIGIT_CODE = {{(BIN_WIDTH-4){1'b0}}, ovf_q ? DASH_CODE : nib};
    end

    assign OVERFLOW = ovf_q;

endmodule
